// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: sequencer states, register index width,
// instruction size and the default reset/trap vectors.
package pc_sequencer_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of every signal exchanged between the PC sequencer and the pipeline.
// The master side is the sequencer, the slave side is the pipeline datapath.
interface pc_sequencer_if import pc_sequencer_pkg::*; #(parameter int ADDR_W = 32);

  logic [ADDR_W-1:0]    pc;
  logic [ADDR_W-1:0]    next_PC;
  logic                 pc_write;
  logic                 ifid_write;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic [REG_IDX_W-1:0] id_rs;
  logic [REG_IDX_W-1:0] id_rt;
  logic                 id_jump;
  logic [ADDR_W-1:0]    id_jump_target;
  logic                 id_halt;
  logic                 ex_mem_read;
  logic [REG_IDX_W-1:0] ex_rt;
  logic                 ex_branch_taken;
  logic [ADDR_W-1:0]    ex_branch_target;
  logic                 trap_req;
  logic                 resume;
  logic [ADDR_W-1:0]    epc;
  logic [1:0]           state;
  logic [31:0]          stall_count;

  modport master (
    input  pc, id_rs, id_rt, id_jump, id_jump_target, id_halt,
           ex_mem_read, ex_rt, ex_branch_taken, ex_branch_target, trap_req, resume,
    output next_PC, pc_write, ifid_write, ifid_flush, idex_flush, epc, state, stall_count
  );

  modport slave (
    output pc, id_rs, id_rt, id_jump, id_jump_target, id_halt,
           ex_mem_read, ex_rt, ex_branch_taken, ex_branch_target, trap_req, resume,
    input  next_PC, pc_write, ifid_write, ifid_flush, idex_flush, epc, state, stall_count
  );

endinterface

// File: rtl/pc_sequencer_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination is read by the
// instruction in ID. Register 0 never creates a dependency.
module pc_sequencer_hazard_detect import pc_sequencer_pkg::*; (
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rt,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  output logic                 load_use
);

  assign load_use = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and pipeline stall/flush control for the 5-stage MIPS pipeline.
// Control outputs are combinational; state, epc and the stall counter are registered.
module pc_sequencer import pc_sequencer_pkg::*; #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(DEF_TRAP_VECTOR)
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.master bus
);

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic              capture_epc;
  logic              load_use;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] epc_q;
  logic [31:0]       stall_q;

  pc_sequencer_hazard_detect u_hazard (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .load_use    (load_use)
  );

  assign pc_plus4 = bus.pc + ADDR_W'(INSTR_BYTES);

  // Priority mux: trap beats everything and is the only event that wakes a halted core
  // besides resume; wrong-path branch/jump requests are dropped during FLUSH.
  always_comb begin
    state_d        = ST_RUN;
    capture_epc    = 1'b0;
    bus.next_PC    = pc_plus4;
    bus.pc_write   = 1'b1;
    bus.ifid_write = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_flush = 1'b0;
    if (reset) begin
      bus.next_PC    = RESET_VECTOR;
      bus.pc_write   = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (bus.trap_req) begin
      bus.next_PC    = TRAP_VECTOR;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
      capture_epc    = 1'b1;
      state_d        = ST_FLUSH;
    end else if (state_q == ST_HALTED) begin
      bus.idex_flush = 1'b1;
      if (bus.resume) begin
        bus.ifid_flush = 1'b1;
      end else begin
        bus.next_PC    = bus.pc;
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
        state_d        = ST_HALTED;
      end
    end else if (bus.ex_branch_taken && (state_q != ST_FLUSH)) begin
      bus.next_PC    = bus.ex_branch_target;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
      state_d        = ST_FLUSH;
    end else if (load_use) begin
      bus.next_PC    = bus.pc;
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.idex_flush = 1'b1;
      state_d        = ST_LSTALL;
    end else if (bus.id_jump && (state_q != ST_FLUSH)) begin
      bus.next_PC    = bus.id_jump_target;
      bus.ifid_flush = 1'b1;
    end else if (bus.id_halt) begin
      bus.next_PC    = bus.pc;
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      state_d        = ST_HALTED;
    end
  end

  // State, trap return address and saturating count of cycles without a PC update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      epc_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture_epc) begin
        epc_q <= bus.pc;
      end
      if (!bus.pc_write && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign bus.epc         = epc_q;
  assign bus.state       = state_q;
  assign bus.stall_count = stall_q;

endmodule
